mmio_decoder: RTL and testbench
===============================

Name: mmio_decoder

Overview:
- Parametrised memory-mapped I/O decoder between the processor bus (addr/dout/w/din) and its slaves: one synchronous RAM, NUM_OUT registered output ports and one synchronised input port.
- Generalises the fixed two-region RAM/LED decode of the current system top.
- Adds read-data muxing aligned to RAM latency, per-port write strobes and unmapped-write error capture.
- Instantiated once in the system top in place of the hand-written decode and LED register.

Parameters:
DATA_W, 9, bus data width
ADDR_W, 9, processor address width; must be >= RAM_AW+2
RAM_AW, 7, RAM word-address width; region field = addr[RAM_AW+1:RAM_AW]
NUM_OUT, 2, number of output port registers (1..2^RAM_AW)
ERR_CNT_W, 8, width of the saturating error counter

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous reset, active-high
addr  in  ADDR_W  processor address
dout  in  DATA_W  processor write data
w  in  1  processor write enable
din  out  DATA_W  read data to processor
ram_addr  out  RAM_AW  RAM address = addr[RAM_AW-1:0]
ram_data  out  DATA_W  RAM write data = dout
ram_wren  out  1  RAM write enable
ram_q  in  DATA_W  RAM read data, 1-cycle latency
out_ports  out  NUM_OUT*DATA_W  output port registers, port k at [k*DATA_W +: DATA_W]
out_strobe  out  NUM_OUT  one-cycle pulse per port on update
in_port  in  DATA_W  asynchronous external input (switches)
bus_err  out  1  sticky unmapped-write flag
err_addr  out  ADDR_W  address of first unmapped write
err_cnt  out  ERR_CNT_W  saturating count of unmapped writes

Behaviour:
Decode (combinational):
- Mapped only if addr[ADDR_W-1:RAM_AW+2] == 0. Region field values:
  - 00 = RAM.
  - 01 = OUT; port index = addr[IW-1:0], IW = max(1, clog2(NUM_OUT)). Mapped only if index < NUM_OUT and addr[RAM_AW-1:IW] == 0.
  - 10 = IN; offset must be 0.
  - 11 = unmapped.
- ram_wren = w & RAM region. ram_addr and ram_data pass through unregistered.

Output port write:
- w=1 to OUT port k in cycle t: out_ports[k] <= dout at the end of t.
- out_strobe[k] = 1 for exactly cycle t+1 only.
- Other ports and strobes are unchanged or 0.
- Back-to-back writes to the same port give consecutive strobes; the last value wins.

Read path:
- Registered select sel_q <= {region, index, mapped} every cycle, regardless of w.
- din in cycle t+1 is selected by sel_q:
  - RAM: ram_q.
  - OUT k: current out_ports[k], including a write completed at the end of t.
  - IN: in_sync2.
  - Unmapped: all zeros.
- Read latency is 1 cycle, identical for all regions.

Input sync:
- in_sync1 <= in_port; in_sync2 <= in_sync1.
- An in_port change is visible on din no earlier than 2 cycles later.

Error capture:
- Applies to w=1 to an unmapped address (reads never flag).
- err_cnt increments, saturating at all-ones.
- If bus_err == 0: bus_err <= 1 and err_addr <= addr. Later errors do not change err_addr.
- Only rst clears these.
- Unmapped writes must not assert ram_wren or any out_strobe, and must not change any out_port.

Reset:
- Synchronous: on rst=1 at a clock edge, all registers go to 0 (out_ports, out_strobe, sel_q, in_sync*, bus_err, err_addr, err_cnt).
- rst overrides a simultaneous write: the port stays 0 and no strobe follows.
- din after reset = ram_q, since sel_q = RAM region, address 0.
- ram_wren stays combinational and is not gated by rst.

Test Plan:
- Defaults, w=1, addr=0x005, dout=0x1A5: ram_wren=1, ram_addr=5 that cycle. Next cycle with w=0, addr=5: din=0x1A5 one cycle later.
- w=1 addr=0x080 dout=0x0F0, then addr=0x081 dout=0x111 back-to-back: out_strobe=01 then 10; port0=0x0F0, port1=0x111. Read addr 0x081 -> din=0x111 after 1 cycle.
- in_port 0x000->0x155 at cycle t, addr=0x100 held: din stays 0x000 through t+1 and reads 0x155 by t+3 at latest.
- w=1 addr=0x082 (index 2 >= NUM_OUT) then addr=0x180: bus_err=1, err_addr=0x082, err_cnt=2; no strobe, no ram_wren, ports unchanged. Then 300 more unmapped writes: err_cnt=0xFF.
- Write port0=0x033, then rst=1 coincident with a write of 0x1FF to port0: after the edge, port0=0, out_strobe=0, bus_err=0, err_cnt=0, din follows ram_q.
- NUM_OUT=1 build: addr 0x080 maps to port0 and addr 0x081 flags an error.

Source files
------------

// File: rtl/mmio_decoder.sv
// MMIO decoder: routes processor bus accesses to a synchronous RAM, registered
// output ports and a synchronised input port, and records unmapped writes.
module mmio_decoder #(
  parameter int DATA_W    = 9,
  parameter int ADDR_W    = 9,
  parameter int RAM_AW    = 7,
  parameter int NUM_OUT   = 2,
  parameter int ERR_CNT_W = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ADDR_W-1:0]           addr,
  input  logic [DATA_W-1:0]           dout,
  input  logic                        w,
  output logic [DATA_W-1:0]           din,
  output logic [RAM_AW-1:0]           ram_addr,
  output logic [DATA_W-1:0]           ram_data,
  output logic                        ram_wren,
  input  logic [DATA_W-1:0]           ram_q,
  output logic [NUM_OUT*DATA_W-1:0]   out_ports,
  output logic [NUM_OUT-1:0]          out_strobe,
  input  logic [DATA_W-1:0]           in_port,
  output logic                        bus_err,
  output logic [ADDR_W-1:0]           err_addr,
  output logic [ERR_CNT_W-1:0]        err_cnt
);

  localparam int IW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam logic [IW:0] NUM_OUT_L = NUM_OUT[IW:0];

  typedef enum logic [1:0] {
    RGN_RAM  = 2'b00,
    RGN_OUT  = 2'b01,
    RGN_IN   = 2'b10,
    RGN_NONE = 2'b11
  } region_e;

  region_e             region_s;
  logic [RAM_AW-1:0]   offset_s;
  logic [IW-1:0]       index_s;
  logic                hi_zero_s;
  logic                idx_ok_s;
  logic                mapped_s;
  logic                out_wr_s;
  logic                err_wr_s;
  logic [DATA_W-1:0]   rd_port_s;
  logic [DATA_W-1:0]   din_s;

  region_e             sel_region_r;
  logic [IW-1:0]       sel_index_r;
  logic                sel_unmap_r;
  logic [DATA_W-1:0]   port_r [NUM_OUT];
  logic [NUM_OUT-1:0]  out_strobe_r;
  logic [DATA_W-1:0]   in_sync1_r;
  logic [DATA_W-1:0]   in_sync2_r;
  logic                bus_err_r;
  logic [ADDR_W-1:0]   err_addr_r;
  logic [ERR_CNT_W-1:0] err_cnt_r;

  // Address decode: region field, port index and mapped qualification.
  always_comb begin
    offset_s  = addr[RAM_AW-1:0];
    region_s  = region_e'(addr[RAM_AW+1:RAM_AW]);
    index_s   = addr[IW-1:0];
    hi_zero_s = ((addr >> (RAM_AW + 2)) == {ADDR_W{1'b0}});
    idx_ok_s  = ({1'b0, index_s} < NUM_OUT_L) &&
                ((offset_s >> IW) == {RAM_AW{1'b0}});
    case (region_s)
      RGN_RAM: mapped_s = hi_zero_s;
      RGN_OUT: mapped_s = hi_zero_s && idx_ok_s;
      RGN_IN:  mapped_s = hi_zero_s && (offset_s == {RAM_AW{1'b0}});
      default: mapped_s = 1'b0;
    endcase
    out_wr_s = w && mapped_s && (region_s == RGN_OUT);
    err_wr_s = w && !mapped_s;
  end

  assign ram_addr = offset_s;
  assign ram_data = dout;
  assign ram_wren = w && mapped_s && (region_s == RGN_RAM);

  // Read select is captured every cycle so din lines up with the RAM latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_region_r <= RGN_RAM;
      sel_index_r  <= {IW{1'b0}};
      sel_unmap_r  <= 1'b0;
    end else begin
      sel_region_r <= region_s;
      sel_index_r  <= index_s;
      sel_unmap_r  <= !mapped_s;
    end
  end

  // Output port registers and their one-cycle update strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_OUT; k++) begin
        port_r[k] <= {DATA_W{1'b0}};
      end
      out_strobe_r <= {NUM_OUT{1'b0}};
    end else begin
      out_strobe_r <= {NUM_OUT{1'b0}};
      for (int k = 0; k < NUM_OUT; k++) begin
        if (out_wr_s && (index_s == IW'(k))) begin
          port_r[k]       <= dout;
          out_strobe_r[k] <= 1'b1;
        end
      end
    end
  end

  // Two-flop synchroniser for the asynchronous switch input.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_sync1_r <= {DATA_W{1'b0}};
      in_sync2_r <= {DATA_W{1'b0}};
    end else begin
      in_sync1_r <= in_port;
      in_sync2_r <= in_sync1_r;
    end
  end

  // Sticky error flag, first-offender address and saturating counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_err_r  <= 1'b0;
      err_addr_r <= {ADDR_W{1'b0}};
      err_cnt_r  <= {ERR_CNT_W{1'b0}};
    end else if (err_wr_s) begin
      if (err_cnt_r != {ERR_CNT_W{1'b1}}) begin
        err_cnt_r <= err_cnt_r + ERR_CNT_W'(1);
      end
      if (!bus_err_r) begin
        bus_err_r  <= 1'b1;
        err_addr_r <= addr;
      end
    end
  end

  // Read-data mux driven by last cycle's select; RAM data arrives this cycle.
  always_comb begin
    rd_port_s = {DATA_W{1'b0}};
    for (int k = 0; k < NUM_OUT; k++) begin
      rd_port_s = (sel_index_r == IW'(k)) ? port_r[k] : rd_port_s;
    end
    if (sel_unmap_r) begin
      din_s = {DATA_W{1'b0}};
    end else begin
      case (sel_region_r)
        RGN_RAM: din_s = ram_q;
        RGN_OUT: din_s = rd_port_s;
        RGN_IN:  din_s = in_sync2_r;
        default: din_s = {DATA_W{1'b0}};
      endcase
    end
  end

  // Flatten the port array onto the output bus.
  always_comb begin
    out_ports = {(NUM_OUT*DATA_W){1'b0}};
    for (int k = 0; k < NUM_OUT; k++) begin
      out_ports[k*DATA_W +: DATA_W] = port_r[k];
    end
  end

  assign din        = din_s;
  assign out_strobe = out_strobe_r;
  assign bus_err    = bus_err_r;
  assign err_addr   = err_addr_r;
  assign err_cnt    = err_cnt_r;

  mmio_decoder_chk #(
    .ADDR_W (ADDR_W),
    .RAM_AW (RAM_AW)
  ) u_chk (
    .clk      (clk),
    .w        (w),
    .ram_wren (ram_wren),
    .addr     (addr)
  );

endmodule

// Structural invariants of the RAM write enable.
module mmio_decoder_chk #(
  parameter int ADDR_W = 9,
  parameter int RAM_AW = 7
) (
  input logic              clk,
  input logic              w,
  input logic              ram_wren,
  input logic [ADDR_W-1:0] addr
);

  a_wren_needs_w: assert property (@(posedge clk) ram_wren |-> w);
  a_wren_in_ram:  assert property (@(posedge clk)
                    ram_wren |-> ((addr >> RAM_AW) == {ADDR_W{1'b0}}));

endmodule

// File: tb/tb_mmio_decoder.sv
// Randomised scoreboard bench for mmio_decoder; runs a NUM_OUT=2 and a
// NUM_OUT=1 instance side by side on the same bus against one reference model.
module tb_mmio_decoder;

  localparam int DW  = 9;
  localparam int AW  = 9;
  localparam int RAW = 7;
  localparam int EW  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, w;
  logic [AW-1:0] addr;
  logic [DW-1:0] dout, in_port, ram_q;

  logic [DW-1:0]   din0, ram_data0, din1, ram_data1;
  logic [RAW-1:0]  ram_addr0, ram_addr1;
  logic            ram_wren0, ram_wren1, bus_err0, bus_err1;
  logic [2*DW-1:0] out_ports0;
  logic [DW-1:0]   out_ports1;
  logic [1:0]      out_strobe0;
  logic [0:0]      out_strobe1;
  logic [AW-1:0]   err_addr0, err_addr1;
  logic [EW-1:0]   err_cnt0, err_cnt1;

  mmio_decoder #(.DATA_W(DW), .ADDR_W(AW), .RAM_AW(RAW), .NUM_OUT(2), .ERR_CNT_W(EW)) u_dut0 (
    .clk(clk), .rst(rst), .addr(addr), .dout(dout), .w(w), .din(din0),
    .ram_addr(ram_addr0), .ram_data(ram_data0), .ram_wren(ram_wren0), .ram_q(ram_q),
    .out_ports(out_ports0), .out_strobe(out_strobe0), .in_port(in_port),
    .bus_err(bus_err0), .err_addr(err_addr0), .err_cnt(err_cnt0));

  mmio_decoder #(.DATA_W(DW), .ADDR_W(AW), .RAM_AW(RAW), .NUM_OUT(1), .ERR_CNT_W(EW)) u_dut1 (
    .clk(clk), .rst(rst), .addr(addr), .dout(dout), .w(w), .din(din1),
    .ram_addr(ram_addr1), .ram_data(ram_data1), .ram_wren(ram_wren1), .ram_q(ram_q),
    .out_ports(out_ports1), .out_strobe(out_strobe1), .in_port(in_port),
    .bus_err(bus_err1), .err_addr(err_addr1), .err_cnt(err_cnt1));

  // Environment RAM: read-before-write, one cycle of read latency.
  logic [DW-1:0] ram_mem [128];
  always @(posedge clk) begin
    if (ram_wren0) ram_mem[ram_addr0] <= ram_data0;
    ram_q <= ram_mem[ram_addr0];
  end

  typedef struct packed {
    logic                     chk;
    logic                     wren;
    logic [RAW-1:0]           raddr;
    logic [DW-1:0]            rdata;
    logic [1:0][DW-1:0]       din;
    logic [1:0][1:0]          strb;
    logic [1:0][1:0][DW-1:0]  p;
    logic [1:0]               berr;
    logic [1:0][AW-1:0]       eaddr;
    logic [1:0][EW-1:0]       ecnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state: index 0 is the two-port build, 1 the one-port build.
  logic [DW-1:0] m_ports [2][2];
  logic [1:0]    m_strb  [2];
  logic [DW-1:0] m_din   [2];
  logic          m_berr  [2];
  logic [AW-1:0] m_eaddr [2];
  int            m_ecnt  [2];
  logic [DW-1:0] m_sync1, m_sync2;
  logic [DW-1:0] m_mem [128];
  bit            started = 1'b0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: one expectation record per cycle, checked mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      if (mon_e.chk) begin
        cmp("ram_wren0", 32'(ram_wren0), 32'(mon_e.wren));
        cmp("ram_wren1", 32'(ram_wren1), 32'(mon_e.wren));
        cmp("ram_addr0", 32'(ram_addr0), 32'(mon_e.raddr));
        cmp("ram_addr1", 32'(ram_addr1), 32'(mon_e.raddr));
        cmp("ram_data0", 32'(ram_data0), 32'(mon_e.rdata));
        cmp("ram_data1", 32'(ram_data1), 32'(mon_e.rdata));
        cmp("din0",      32'(din0),        32'(mon_e.din[0]));
        cmp("din1",      32'(din1),        32'(mon_e.din[1]));
        cmp("strobe0",   32'(out_strobe0), 32'(mon_e.strb[0]));
        cmp("strobe1",   32'(out_strobe1), 32'(mon_e.strb[1]));
        cmp("ports0",    32'(out_ports0),  32'(mon_e.p[0]));
        cmp("ports1",    32'(out_ports1),  32'(mon_e.p[1][0]));
        cmp("bus_err0",  32'(bus_err0),    32'(mon_e.berr[0]));
        cmp("bus_err1",  32'(bus_err1),    32'(mon_e.berr[1]));
        cmp("err_addr0", 32'(err_addr0),   32'(mon_e.eaddr[0]));
        cmp("err_addr1", 32'(err_addr1),   32'(mon_e.eaddr[1]));
        cmp("err_cnt0",  32'(err_cnt0),    32'(mon_e.ecnt[0]));
        cmp("err_cnt1",  32'(err_cnt1),    32'(mon_e.ecnt[1]));
      end
    end
  end

  // Drive one bus cycle, queue what must be seen during it, then advance the model.
  task automatic step(input logic r, input logic wv, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [DW-1:0] iv);
    exp_t          e;
    logic [DW-1:0] old_ram;
    int            ai, rg, off, kind, nout;
    bit            hi;
    rst = r; w = wv; addr = a; dout = d; in_port = iv;
    ai  = int'(a);
    hi  = (ai / 512) == 0;
    rg  = (ai / 128) % 4;
    off = ai % 128;
    e = '0;
    e.chk   = started;
    e.wren  = wv && hi && (rg == 0);
    e.raddr = RAW'(off);
    e.rdata = d;
    for (int c = 0; c < 2; c++) begin
      e.din[c]   = m_din[c];
      e.strb[c]  = m_strb[c];
      e.p[c][0]  = m_ports[c][0];
      e.p[c][1]  = m_ports[c][1];
      e.berr[c]  = m_berr[c];
      e.eaddr[c] = m_eaddr[c];
      e.ecnt[c]  = EW'(m_ecnt[c]);
    end
    exp_q.push_back(e);
    started = 1'b1;

    old_ram = m_mem[off];
    for (int c = 0; c < 2; c++) begin
      nout = (c == 0) ? 2 : 1;
      if (hi && rg == 0)                      kind = 0;
      else if (hi && rg == 1 && off < nout)   kind = 1;
      else if (hi && rg == 2 && off == 0)     kind = 2;
      else                                    kind = 3;
      if (r) begin
        m_ports[c][0] = '0; m_ports[c][1] = '0;
        m_strb[c] = '0; m_berr[c] = 1'b0; m_eaddr[c] = '0; m_ecnt[c] = 0;
        m_din[c] = old_ram;
      end else begin
        m_strb[c] = '0;
        if (wv && kind == 1) begin
          m_ports[c][off] = d;
          m_strb[c][off]  = 1'b1;
        end
        if (wv && kind == 3) begin
          if (!m_berr[c]) begin
            m_berr[c]  = 1'b1;
            m_eaddr[c] = a;
          end
          if (m_ecnt[c] < 255) m_ecnt[c]++;
        end
        case (kind)
          0:       m_din[c] = old_ram;
          1:       m_din[c] = m_ports[c][off];
          2:       m_din[c] = m_sync1;
          default: m_din[c] = '0;
        endcase
      end
    end
    if (r) begin
      m_sync1 = '0; m_sync2 = '0;
    end else begin
      m_sync2 = m_sync1; m_sync1 = iv;
    end
    if (wv && hi && rg == 0) m_mem[off] = d;
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] cur_in;
  logic [AW-1:0] ra;
  logic [1:0]    rrg;
  logic [RAW-1:0] roff;

  initial begin
    rst = 1'b1; w = 1'b0; addr = '0; dout = '0; in_port = '0; cur_in = '0;
    for (int i = 0; i < 128; i++) begin
      ram_mem[i] = DW'($urandom);
      m_mem[i]   = ram_mem[i];
    end
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 9'h000, 9'h000, 9'h000);
    step(1'b1, 1'b0, 9'h000, 9'h000, 9'h000);

    // RAM write then read back.
    step(1'b0, 1'b1, 9'h005, 9'h1A5, 9'h000);
    step(1'b0, 1'b0, 9'h005, 9'h000, 9'h000);
    step(1'b0, 1'b0, 9'h000, 9'h000, 9'h000);

    // Back-to-back port writes and read-back.
    step(1'b0, 1'b1, 9'h080, 9'h0F0, 9'h000);
    step(1'b0, 1'b1, 9'h081, 9'h111, 9'h000);
    step(1'b0, 1'b0, 9'h081, 9'h000, 9'h000);
    step(1'b0, 1'b1, 9'h081, 9'h0AA, 9'h000);
    step(1'b0, 1'b1, 9'h081, 9'h055, 9'h000);
    step(1'b0, 1'b0, 9'h080, 9'h000, 9'h000);

    // Input synchroniser latency.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 9'h100, 9'h000, 9'h000);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 9'h100, 9'h000, 9'h155);
    step(1'b0, 1'b0, 9'h101, 9'h000, 9'h155);

    // Unmapped writes, then saturate the counter.
    step(1'b0, 1'b1, 9'h082, 9'h123, 9'h155);
    step(1'b0, 1'b1, 9'h180, 9'h0FF, 9'h155);
    step(1'b0, 1'b0, 9'h180, 9'h000, 9'h155);
    for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 9'h180 + 9'(i % 64), DW'($urandom), 9'h155);
    step(1'b0, 1'b0, 9'h080, 9'h000, 9'h155);

    // Reset coincident with a port write.
    step(1'b0, 1'b1, 9'h080, 9'h033, 9'h155);
    step(1'b1, 1'b1, 9'h080, 9'h1FF, 9'h155);
    step(1'b0, 1'b0, 9'h007, 9'h000, 9'h155);
    step(1'b0, 1'b0, 9'h080, 9'h000, 9'h155);

    // Random traffic biased towards region boundaries.
    for (int i = 0; i < 2000; i++) begin
      rrg  = 2'($urandom_range(0, 3));
      roff = ($urandom_range(0, 3) == 0) ? RAW'($urandom) : RAW'($urandom_range(0, 2));
      ra   = {rrg, roff};
      if ($urandom_range(0, 7) == 0) cur_in = DW'($urandom);
      step(($urandom_range(0, 199) == 0), 1'($urandom), ra, DW'($urandom), cur_in);
    end
    step(1'b0, 1'b0, 9'h000, 9'h000, cur_in);

    cmp("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
